past_counter_array: RTL

//  Multi-channel countdown engine; parametrised successor of the single-channel PastAssert

---
 rtl/past_counter_array.sv | 121 ++++++++++++
 1 files changed

// File: rtl/past_counter_array.sv
// Pool of NUM_CHANNELS independent down-counters with a shared start method, per-channel cancel and done pulses.
// Optional build macro PCT_RELOAD_EN adds periodic auto-reload mode (startSignal_periodic port).
module past_counter_array #(
  parameter int F_TESTID     = 9999,
  parameter int NUM_CHANNELS = 4,
  parameter int MAX_AMOUNT   = 22,
  parameter int COUNT_WIDTH  = 5,
  parameter int CHAN_WIDTH   = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    startSignal__ENA,
  input  logic [CHAN_WIDTH-1:0]   startSignal_chan,
  input  logic [COUNT_WIDTH-1:0]  startSignal_amount,
`ifdef PCT_RELOAD_EN
  input  logic                    startSignal_periodic,
`endif
  output logic                    startSignal__RDY,
  input  logic                    stopSignal__ENA,
  input  logic [CHAN_WIDTH-1:0]   stopSignal_chan,
  output logic                    stopSignal__RDY,
  output logic [NUM_CHANNELS-1:0] busy,
  output logic                    busy__RDY,
  output logic [NUM_CHANNELS-1:0] done
);

  localparam int CHAN_SLOTS = 1 << CHAN_WIDTH;

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 32 || CHAN_SLOTS < NUM_CHANNELS ||
      (1 << COUNT_WIDTH) <= MAX_AMOUNT || F_TESTID < 0) begin : gBadParams
    $error("past_counter_array: inconsistent parameters");
  end

  logic [CHAN_SLOTS-1:0]  idleExt;
  logic [COUNT_WIDTH-1:0] loadVal;
  logic                   stopSameChan;

  assign loadVal = (startSignal_amount > COUNT_WIDTH'(MAX_AMOUNT)) ?
                   COUNT_WIDTH'(MAX_AMOUNT) : startSignal_amount;
  assign stopSameChan = stopSignal__ENA && (stopSignal_chan == startSignal_chan);

  // Unpopulated channel slots read as never idle, so out-of-range starts are refused.
  for (genvar gi = 0; gi < CHAN_SLOTS; gi++) begin : gIdle
    if (gi < NUM_CHANNELS) begin : gReal
      assign idleExt[gi] = !busy[gi];
    end else begin : gVoid
      assign idleExt[gi] = 1'b0;
    end
  end

  assign startSignal__RDY = idleExt[startSignal_chan] && !stopSameChan;
  assign stopSignal__RDY  = 1'b1;
  assign busy__RDY        = 1'b1;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : gChan
    logic [COUNT_WIDTH-1:0] counterReg, counterNext;
    logic                   doneReg, doneNext;
    logic                   startHit, stopHit;
`ifdef PCT_RELOAD_EN
    logic [COUNT_WIDTH-1:0] reloadReg, reloadNext;
    logic                   periodicReg, periodicNext;
`endif

    assign startHit = startSignal__ENA && startSignal__RDY &&
                      (startSignal_chan == CHAN_WIDTH'(gi));
    assign stopHit  = stopSignal__ENA && (stopSignal_chan == CHAN_WIDTH'(gi));

    // Stop beats both a fresh load and natural expiry on the same edge.
    always_comb begin
      counterNext = counterReg;
      doneNext    = 1'b0;
`ifdef PCT_RELOAD_EN
      reloadNext   = reloadReg;
      periodicNext = periodicReg;
`endif
      if (stopHit) begin
        counterNext = '0;
`ifdef PCT_RELOAD_EN
        periodicNext = 1'b0;
`endif
      end else if (startHit) begin
        counterNext = loadVal;
`ifdef PCT_RELOAD_EN
        periodicNext = startSignal_periodic && (loadVal != '0);
        reloadNext   = loadVal;
`endif
      end else if (counterReg == COUNT_WIDTH'(1)) begin
        doneNext = 1'b1;
`ifdef PCT_RELOAD_EN
        counterNext = periodicReg ? reloadReg : '0;
`else
        counterNext = '0;
`endif
      end else if (counterReg != '0) begin
        counterNext = counterReg - COUNT_WIDTH'(1);
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        counterReg <= '0;
        doneReg    <= 1'b0;
`ifdef PCT_RELOAD_EN
        reloadReg   <= '0;
        periodicReg <= 1'b0;
`endif
      end else begin
        counterReg <= counterNext;
        doneReg    <= doneNext;
`ifdef PCT_RELOAD_EN
        reloadReg   <= reloadNext;
        periodicReg <= periodicNext;
`endif
      end
    end

    assign busy[gi] = (counterReg != '0);
    assign done[gi] = doneReg;
  end

endmodule
